// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic datapath (subtractor and adder).
// Contents:
//   state_e - sequencer state encoding, also used by the serial adder controller.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  in  minuend / subtrahend bits
//   bin   in  borrow in
//   d     out difference bit
//   bout  out borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when b exceeds a, or when a == b and a borrow came in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   operation request, sampled only while idle
//   a, b       in   minuend / subtrahend, captured when start is accepted
//   busy       out  high while bits are being shifted
//   done       out  one-cycle pulse when diff/borrow hold the new result
//   diff       out  registered result
//   borrow     out  registered final borrow (1 when a < b, unsigned)
//   state_dbg  out  current sequencer state
//
// Handshake: start is accepted on any clock edge where the block is idle and
// start is high; a and b are captured on that same edge. Starts seen while
// busy or while done is high are dropped, not queued. After acceptance busy
// stays high for WIDTH cycles, then done pulses for one cycle, and diff/borrow
// stay stable from that pulse until the next accepted start.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output state_e           state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             br_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             d_bit;
    logic             bo_bit;

    full_subtractor u_fs (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (bo_bit)
    );

    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)    state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            br_q   <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            // busy/done are registered from the next state so they line up
            // exactly with the state they describe.
            busy  <= (state_next == ST_SHIFT);
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        br_q   <= 1'b0;
                        cnt    <= '0;
                        diff   <= '0;
                        borrow <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    // Result enters at the MSB so after WIDTH shifts bit 0 is the LSB.
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    br_q <= bo_bit;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        borrow <= bo_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;
    state_e     st4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    state_e     st8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .state_dbg(st4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .state_dbg(st8)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    longint cyc  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    // ---------------- behavioural model ----------------
    // Per instance: idle flag, edges since acceptance, full (WIDTH+1)-bit
    // result of {0,a}-{0,b}, and the visible diff/borrow.
    bit     m_idle[2];
    int     m_p[2];
    longint m_res[2];
    longint m_diff[2];
    bit     m_borrow[2];
    longint m_acc[2];
    int     n_acc8 = 0;
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int     w;
            bit     s;
            longint av, bv;
            w  = wid(i);
            s  = (i == 0) ? start4 : start8;
            av = (i == 0) ? longint'(a4) : longint'(a8);
            bv = (i == 0) ? longint'(b4) : longint'(b8);
            if (!reset) begin
                m_idle[i] = 1; m_p[i] = 0; m_diff[i] = 0; m_borrow[i] = 0;
                if (i == 1) exp_q.delete();
            end else if (m_idle[i]) begin
                if (s) begin
                    m_idle[i]   = 0;
                    m_p[i]      = 0;
                    m_res[i]    = (av - bv) & ((longint'(1) << (w + 1)) - 1);
                    m_diff[i]   = 0;
                    m_borrow[i] = 0;
                    m_acc[i]    = cyc;
                    if (i == 1) begin
                        exp_q.push_back(m_res[i][8:0]);
                        n_acc8++;
                    end
                end
            end else begin
                m_p[i]++;
                if (m_p[i] <= w) begin
                    // After p shifts the low p result bits sit in the top p positions.
                    m_diff[i] = (m_res[i] & ((longint'(1) << m_p[i]) - 1)) << (w - m_p[i]);
                    if (m_p[i] == w) m_borrow[i] = m_res[i][w];
                end else begin
                    m_idle[i] = 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                int     w;
                longint e_busy, e_done, e_state;
                longint g_busy, g_done, g_diff, g_borrow, g_state;
                w       = wid(i);
                e_busy  = (!m_idle[i] && m_p[i] < w) ? 1 : 0;
                e_done  = (!m_idle[i] && m_p[i] == w) ? 1 : 0;
                e_state = m_idle[i] ? 0 : (m_p[i] < w ? 1 : 2);
                g_busy   = (i == 0) ? longint'(busy4)   : longint'(busy8);
                g_done   = (i == 0) ? longint'(done4)   : longint'(done8);
                g_diff   = (i == 0) ? longint'(diff4)   : longint'(diff8);
                g_borrow = (i == 0) ? longint'(borrow4) : longint'(borrow8);
                g_state  = (i == 0) ? longint'(st4)     : longint'(st8);
                check($sformatf("busy_w%0d", w),   g_busy,   e_busy);
                check($sformatf("done_w%0d", w),   g_done,   e_done);
                check($sformatf("diff_w%0d", w),   g_diff,   m_diff[i]);
                check($sformatf("borrow_w%0d", w), g_borrow, longint'(m_borrow[i]));
                check($sformatf("state_w%0d", w),  g_state,  e_state);
                if (g_done == 1 && !m_idle[i])
                    check($sformatf("latency_w%0d", w), cyc - m_acc[i] + 1, w + 1);
            end
            if (done8) begin
                if (exp_q.size() == 0) check("sb8_unexpected_done", 1, 0);
                else check("sb8_result", longint'({borrow8, diff8}), longint'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // From the current negedge, wait (bounded) until done4 is high.
    task automatic wait_done4(output int cycles, output int busy_n);
        cycles = 1;
        busy_n = 0;
        while (!done4 && cycles < 40) begin
            if (busy4) busy_n++;
            @(negedge clk);
            cycles++;
        end
        if (!done4) check("wait_done4_timeout", 0, 1);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input string tag,
                       input logic [3:0] ed, input logic eb);
        int c, bn;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(c, bn);
        check({tag, "_latency"}, c, 5);
        check({tag, "_busy_cycles"}, bn, 4);
        check({tag, "_diff"}, diff4, ed);
        check({tag, "_borrow"}, borrow4, eb);
        @(negedge clk);
        check({tag, "_done_width"}, done4, 0);
        check({tag, "_diff_hold"}, diff4, ed);
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int c, bn;
        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_diff", diff4, 0);
        check("rst_borrow", borrow4, 0);
        reset = 1'b1;

        // Basic subtraction, both borrow outcomes.
        op4(4'd9, 4'd3, "t1", 4'd6, 1'b0);
        op4(4'd3, 4'd9, "t2", 4'hA, 1'b1);

        // Back-to-back with start held through DONE.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        @(negedge clk);
        wait_done4(c, bn);
        check("t3a_diff", diff4, 4'h0);
        check("t3a_borrow", borrow4, 0);
        a4 = 4'h0; b4 = 4'h1;
        c = 0;
        repeat (2) begin @(negedge clk); c++; end
        start4 = 1'b0;
        while (!done4 && c < 40) begin @(negedge clk); c++; end
        check("t3_done_spacing", c, 6);
        check("t3b_diff", diff4, 4'hF);
        check("t3b_borrow", borrow4, 1);

        // Starts and operand changes during SHIFT are ignored.
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'd7; b4 = 4'd9;
        wait_done4(c, bn);
        check("t4_diff", diff4, 4'd3);
        check("t4_borrow", borrow4, 0);
        @(negedge clk);

        // Reset during the second SHIFT cycle.
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy", busy4, 0);
        check("t5_done", done4, 0);
        check("t5_diff", diff4, 0);
        check("t5_borrow", borrow4, 0);
        check("t5_state", st4, 0);
        reset = 1'b1;
        op4(4'd6, 4'd1, "t5_after", 4'd5, 1'b0);

        // Random sweep on the 8-bit instance; starts arrive at random,
        // including while busy and back-to-back.
        c = 0;
        while (n_acc8 < 1000 && c < 40000) begin
            @(negedge clk);
            c++;
            start8 = 1'($urandom_range(0, 1));
            a8 = pick8();
            b8 = pick8();
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_ops_issued", (n_acc8 >= 1000) ? 1 : 0, 1);
        check("t6_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
